// File: rtl/psum_deskew_collector_pkg.sv
// Shared definitions for the systolic array result path: default lane
// width, count-width sizing and lane slicing helpers.
package psum_deskew_collector_pkg;

   localparam int ACC_WIDTH_DEFAULT = 32;

   // Width of a counter that must represent 0..n inclusive.
   function automatic int count_width(input int n);
      return $clog2(n) + 1;
   endfunction

   // Bit offset of lane 'lane' inside a packed row of 'width'-bit lanes.
   function automatic int lane_lsb(input int lane, input int width);
      return lane * width;
   endfunction

endpackage

// File: rtl/psum_row_fifo.sv
// Synchronous FIFO holding aligned psum rows. The head entry is read
// straight from storage so a pushed row is visible on the next cycle.
// Pushes while full are accepted only when a pop frees a slot in the
// same cycle.
module psum_row_fifo
   import psum_deskew_collector_pkg::*;
#(
   parameter int WIDTH = 128,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic                          pop,
   input  logic [WIDTH-1:0]              wdata,
   output logic [WIDTH-1:0]              rdata,
   output logic                          full,
   output logic                          empty,
   output logic [count_width(DEPTH)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = count_width(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);

   // Row storage is not reset; only pointers define what is valid.
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_ptr_q] <= wdata;
   end

   // Occupancy moves only when exactly one of push/pop happens.
   always_comb begin
      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and occupancy registers; depth is a power of two so the
   // pointers wrap naturally.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
      end
   end

   assign rdata = mem_q[rd_ptr_q];
   assign count = count_q;

endmodule

// File: rtl/psum_deskew_collector.sv
// Bottom-row psum collector: removes the one-cycle-per-column skew of the
// systolic array output, buffers aligned rows and hands them out over a
// valid/ready port tagged with their row index inside the tile. The
// array cannot be stalled, so rows arriving at a full buffer are dropped
// and recorded in a sticky overflow flag.
module psum_deskew_collector
   import psum_deskew_collector_pkg::*;
#(
   parameter int ARRAY_COLS = 4,
   parameter int ACC_WIDTH  = ACC_WIDTH_DEFAULT,
   parameter int FIFO_DEPTH = 4,
   parameter int TILE_ROWS  = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                in_valid,
   input  logic [ARRAY_COLS*ACC_WIDTH-1:0]     psum_in,
   output logic                                out_valid,
   input  logic                                out_ready,
   output logic [ARRAY_COLS*ACC_WIDTH-1:0]     out_data,
   output logic [count_width(TILE_ROWS)-1:0]   out_row,
   output logic                                out_last,
   output logic [count_width(FIFO_DEPTH)-1:0]  fifo_count,
   output logic                                overflow,
   input  logic                                clear_ovf
);

   localparam int RW = count_width(TILE_ROWS);
   localparam int RowW = ARRAY_COLS * ACC_WIDTH;

   logic [RowW-1:0] aligned_row;
   logic            aligned_valid;
   logic [RowW-1:0] head_row;
   logic            fifo_full, fifo_empty;
   logic            pop, drop;
   logic [RW-1:0]   row_q, row_d;
   logic            ovf_q, ovf_d;

   // Lane j lags column 0 by j cycles, so it is delayed by the remaining
   // ARRAY_COLS-1-j cycles to line up with the last lane.
   for (genvar gi = 0; gi < ARRAY_COLS; gi++) begin : g_lane
      localparam int DLY = ARRAY_COLS - 1 - gi;
      localparam int LSB = lane_lsb(gi, ACC_WIDTH);
      if (DLY == 0) begin : g_direct
         assign aligned_row[LSB +: ACC_WIDTH] = psum_in[LSB +: ACC_WIDTH];
      end else begin : g_delay
         logic [ACC_WIDTH-1:0] dly_q [DLY];
         // Free-running data delay line; never stalled, never reset.
         always_ff @(posedge clk) begin
            dly_q[0] <= psum_in[LSB +: ACC_WIDTH];
            for (int k = 1; k < DLY; k++) dly_q[k] <= dly_q[k-1];
         end
         assign aligned_row[LSB +: ACC_WIDTH] = dly_q[DLY-1];
      end
   end

   // Row-valid follows column 0 through the full ARRAY_COLS-1 delay.
   if (ARRAY_COLS == 1) begin : g_vld_direct
      assign aligned_valid = in_valid;
   end else begin : g_vld_delay
      localparam int VW = ARRAY_COLS - 1;
      logic [VW-1:0] vld_q;
      // Valid shift register; reset discards rows still in flight.
      always_ff @(posedge clk) begin
         if (rst) vld_q <= '0;
         else     vld_q <= (vld_q << 1) | VW'(in_valid);
      end
      assign aligned_valid = vld_q[VW-1];
   end

   assign out_valid = ~fifo_empty;
   assign pop       = out_valid & out_ready;
   assign drop      = aligned_valid & fifo_full & ~pop;

   psum_row_fifo #(
      .WIDTH (RowW),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (aligned_valid),
      .pop   (pop),
      .wdata (aligned_row),
      .rdata (head_row),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   // Row index advances per accepted row and wraps at the tile size;
   // overflow is sticky with a drop taking priority over a clear.
   always_comb begin
      row_d = row_q;
      if (pop) begin
         if (row_q == RW'(TILE_ROWS - 1)) row_d = '0;
         else                             row_d = row_q + 1'b1;
      end
      ovf_d = ovf_q;
      if (drop)           ovf_d = 1'b1;
      else if (clear_ovf) ovf_d = 1'b0;
   end

   // Row counter and overflow flag registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         row_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         row_q <= row_d;
         ovf_q <= ovf_d;
      end
   end

   assign out_data = out_valid ? head_row : '0;
   assign out_row  = out_valid ? row_q : '0;
   assign out_last = out_valid ? (row_q == RW'(TILE_ROWS - 1)) : 1'(TILE_ROWS == 1);
   assign overflow = ovf_q;

endmodule
